// File: rtl/dm_arbiter_if.sv
// Two-requester data-memory bus: requester side plus shared memory port.
// The slave modport is the arbiter's view; master is the environment's.
interface dm_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  byteen0, byteen1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        stall0, stall1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1,
    input  wdata0, wdata1, byteen0, byteen1,
    output done0, done1, rdata0, rdata1,
    output err0, err1, stall0, stall1,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byteen,
    input  mem_ack, mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1,
    output wdata0, wdata1, byteen0, byteen1,
    input  done0, done1, rdata0, rdata1,
    input  err0, err1, stall0, stall1,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byteen,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter of CPU and DMA/debug onto one data-memory port.
// Optional ack timeout under DM_ARB_TIMEOUT_EN.
module dm_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input logic       clk,
  input logic       reset,
  dm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_vld_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        done0_q, done1_q, err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        r0, r1, pick1, busy, fin, tmo;
  logic [31:0] rd_val;

  // a requester is deaf in its own done cycle
  assign r0    = bus.req0 & ~done0_q;
  assign r1    = bus.req1 & ~done1_q;
  assign pick1 = r1 & (~r0 | (ptr_vld_q & ~ptr_q));
  assign busy  = (state_q != IDLE);
  assign fin   = busy & (bus.mem_ack | tmo);
  assign rd_val = (we_q | tmo) ? 32'h0 : bus.mem_rdata;

`ifdef DM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;

  assign tmo = busy & ~bus.mem_ack &
               (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (!busy || fin)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end
`else
  // never times out; parameter kept referenced for a clean lint
  assign tmo = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (r0 | r1) state_d = pick1 ? GNT1 : GNT0;
      GNT0, GNT1: if (fin) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      ptr_vld_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      done0_q <= fin & (state_q == GNT0);
      done1_q <= fin & (state_q == GNT1);
      if (!busy && (r0 | r1)) begin
        we_q    <= pick1 ? bus.we1     : bus.we0;
        addr_q  <= pick1 ? bus.addr1   : bus.addr0;
        wdata_q <= pick1 ? bus.wdata1  : bus.wdata0;
        be_q    <= pick1 ? bus.byteen1 : bus.byteen0;
      end
      if (fin) begin
        ptr_q     <= (state_q == GNT1);
        ptr_vld_q <= 1'b1;
      end
      if (fin && state_q == GNT0) begin
        err0_q   <= tmo;
        rdata0_q <= rd_val;
      end
      if (fin && state_q == GNT1) begin
        err1_q   <= tmo;
        rdata1_q <= rd_val;
      end
    end
  end

  assign bus.mem_req    = busy;
  assign bus.mem_we     = busy & we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = busy ? wdata_q : 32'h0;
  assign bus.mem_byteen = we_q ? be_q : 4'b0000;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.err0       = err0_q;
  assign bus.err1       = err1_q;
  assign bus.stall0     = bus.req0 & ~done0_q;
  assign bus.stall1     = bus.req1 & ~done1_q;
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL expose parameter TIMEOUT_CYC, default 16, cycles a granted transaction may wait for mem_ack (used only under DM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  transaction request from requester 0 (CPU M stage) / 1 (DMA/debug port).
REQ-005 SHALL have ports we0/we1  input  1  write (1) or read (0).
REQ-006 SHALL have ports addr0/addr1  input  32, wdata0/wdata1  input  32, byteen0/byteen1  input  4  (pre-lane-replicated write data and byte enables).
REQ-007 SHALL have ports done0/done1  output  1  one-cycle completion pulse; rdata0/rdata1  output  32  read data valid with done; err0/err1  output  1  abort flag valid with done.
REQ-008 SHALL have ports stall0/stall1  output  1  = req_x & ~done_x (combinational).
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32, mem_byteen  output  4, mem_ack  input  1, mem_rdata  input  32.

Function
REQ-010 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-011 In IDLE, single active req_x SHALL move to GNTx next cycle; both active SHALL grant the requester opposite the round-robin pointer ptr's last winner (ptr resets to favour requester 0).
REQ-012 On IDLE->GNTx SHALL register we_x, addr_x, wdata_x, byteen_x; memory outputs SHALL be driven only from these registers.
REQ-013 mem_req SHALL be 1 exactly while in GNT0/GNT1; mem_addr/mem_wdata/mem_byteen/mem_we SHALL hold stable throughout.
REQ-014 mem_byteen SHALL be 4'b0000 when latched we=0; mem_wdata SHALL be 0 when mem_req=0.
REQ-015 In GNTx with mem_ack=1, next cycle SHALL: pulse done_x, load rdata_x <= mem_rdata (reads; writes load 0), err_x=0, return to IDLE, set ptr to x.
REQ-016 Minimum latency: req at cycle N, mem_req at N+1, ack at N+1 -> done at N+2; max throughput one transaction per 2 cycles.
REQ-017 In the cycle done_x is high, req_x SHALL be ignored; the other requester MAY be granted.
REQ-018 Write with byteen=4'b0000 SHALL still be issued and completed normally.
REQ-019 rdata_x/err_x SHALL hold their value until the next done_x.
REQ-020 mem_ack in IDLE SHALL be ignored.

Reset
REQ-021 reset SHALL immediately force IDLE, ptr=0, mem_req=0, mem_we=0, mem_addr/mem_wdata=0, mem_byteen=0, done/err/rdata=0, timeout counter=0.
REQ-022 Reset mid-transaction SHALL abandon it without issuing done.

Configuration
REQ-023 With DM_ARB_TIMEOUT_EN defined, a counter SHALL count GNTx cycles without ack; on reaching TIMEOUT_CYC, next cycle SHALL pulse done_x with err_x=1, rdata_x=0, drop mem_req, return to IDLE, set ptr to x.
REQ-024 Ack in the same cycle the count reaches TIMEOUT_CYC SHALL win (normal completion, err=0).
REQ-025 Without DM_ARB_TIMEOUT_EN, GNTx SHALL wait indefinitely and err0/err1 SHALL be constant 0.

Verification
REQ-026 req0 write addr=0x10, wdata=0xAABBCCDD, byteen=4'b1111, ack same cycle -> mem_req 1 cycle, done0 two cycles after req, mem_byteen=4'b1111.
REQ-027 req0 and req1 both held high continuously after reset -> grants alternate 0,1,0,1; neither starved.
REQ-028 req1 read addr=0x20, ack after 3 cycles with mem_rdata=0x12345678 -> mem_byteen=0, done1 with rdata1=0x12345678, stall1 high until done1.
REQ-029 reset asserted during GNT0 -> mem_req low immediately, no done0, IDLE and ptr=0 after release.
REQ-030 DM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, ack never arrives -> done0 with err0=1, rdata0=0, mem_req low; without macro mem_req stays high.
